// File: rtl/kong_pkg.sv
// Shared Kong keypad types, key map and helpers.
package kong_pkg;

    typedef logic [3:0] key_idx;

    localparam key_idx KEY_UP    = 4'd2;
    localparam key_idx KEY_LEFT  = 4'd4;
    localparam key_idx KEY_JUMP  = 4'd5;
    localparam key_idx KEY_RIGHT = 4'd6;
    localparam key_idx KEY_DOWN  = 4'd8;

    localparam int KEYPAD_COLS = 4;

    typedef enum logic [1:0] {
        DRIVE_COL0,
        DRIVE_COL1,
        DRIVE_COL2,
        DRIVE_COL3
    } scan_state_t;

    // Lowest-index set key; 0 when none are set.
    function automatic key_idx lowest_key(input logic [15:0] keys);
        lowest_key = '0;
        for (int i = 15; i >= 0; i--)
            if (keys[i]) lowest_key = key_idx'(i);
    endfunction

endpackage

// File: rtl/kong_key_debounce.sv
// Per-key debouncer: the stable bit follows raw only after DEBOUNCE_SCANS
// consecutive completed scans that disagree with it.
module kong_key_debounce #(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic raw,
    input  logic scan_done,
    output logic stable
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (scan_done) begin
            if (raw == stable) begin
                cnt <= '0;
            end else if (cnt == 4'(DEBOUNCE_SCANS - 1)) begin
                stable <= raw;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/kong_keypad_ctrl.sv
// Kong keypad front end: column scan, row sync, per-key debounce, frame-coherent requests.
// Optional KONG_KEYPAD_AUTOREPEAT_EN: a held jump key re-triggers every JUMP_REPEAT_FRAMES frames.
module kong_keypad_ctrl
    import kong_pkg::*;
#(
    parameter int SCAN_DIV           = 2500,
    parameter int DEBOUNCE_SCANS     = 8,
    parameter int JUMP_REPEAT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       ask_move_up,
    output logic       ask_move_left,
    output logic       ask_move_right,
    output logic       ask_move_down,
    output logic       ask_move_jump,
    output logic       any_key,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    scan_state_t      state;
    logic [DIV_W-1:0] div;
    logic [1:0]       col, next_col;
    logic [3:0]       row_meta, row_sync;
    logic [15:0]      raw, stable;
    logic             scan_done, jump_q, jump_edge, jump_pending, rep_hit;

    assign col      = state;
    assign next_col = col + 2'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Rows are sampled on the last clock of each column so the synchroniser has settled.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= DRIVE_COL0;
            div       <= '0;
            col_n     <= 4'b1110;
            raw       <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (div == DIV_W'(SCAN_DIV - 1)) begin
                div <= '0;
                for (int r = 0; r < KEYPAD_COLS; r++)
                    raw[{2'(r), col}] <= ~row_sync[r];
                state     <= scan_state_t'(next_col);
                col_n     <= ~(4'b0001 << next_col);
                scan_done <= (state == DRIVE_COL3);
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_key
        kong_key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_db (
            .clk       (clk),
            .resetN    (resetN),
            .raw       (raw[k]),
            .scan_done (scan_done),
            .stable    (stable[k])
        );
    end

    assign jump_edge = stable[KEY_JUMP] & ~jump_q;

`ifdef KONG_KEYPAD_AUTOREPEAT_EN
    logic [5:0] rep_cnt;

    assign rep_hit = startOfFrame & stable[KEY_JUMP] & ~jump_edge
                   & (rep_cnt == 6'(JUMP_REPEAT_FRAMES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                              rep_cnt <= '0;
        else if (jump_edge)                       rep_cnt <= '0;
        else if (startOfFrame && stable[KEY_JUMP]) rep_cnt <= rep_hit ? 6'd0 : rep_cnt + 6'd1;
    end
`else
    // No repeat in this build; a zero period is outside the legal range, so this is constant low.
    assign rep_hit = (JUMP_REPEAT_FRAMES == 0);
`endif

    // An edge landing on startOfFrame goes straight to the output and is not queued again.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            jump_q         <= 1'b0;
            jump_pending   <= 1'b0;
            ask_move_up    <= 1'b0;
            ask_move_left  <= 1'b0;
            ask_move_right <= 1'b0;
            ask_move_down  <= 1'b0;
            ask_move_jump  <= 1'b0;
            any_key        <= 1'b0;
            key_code       <= '0;
        end else begin
            jump_q <= stable[KEY_JUMP];
            if (startOfFrame) begin
                jump_pending   <= rep_hit;
                ask_move_up    <= stable[KEY_UP];
                ask_move_left  <= stable[KEY_LEFT];
                ask_move_right <= stable[KEY_RIGHT];
                ask_move_down  <= stable[KEY_DOWN];
                ask_move_jump  <= jump_pending | jump_edge;
                any_key        <= |stable;
                key_code       <= lowest_key(stable);
            end else if (jump_edge) begin
                jump_pending <= 1'b1;
            end
        end
    end

endmodule
